// File: rtl/stopwatch_lap_pkg.sv
// Shared constants, lap state encoding and BCD helpers for the lap stopwatch.
package stopwatch_lap_pkg;

   localparam logic [3:0] BCD_MAX = 4'd9;
   localparam logic [3:0] BCD_MIN = 4'd0;

   typedef enum logic {
      LAP_LIVE = 1'b0,
      LAP_HOLD = 1'b1
   } lap_state_e;

   // Preset nibbles above 9 are not legal BCD; pin them to 9.
   function automatic logic [3:0] clamp_bcd(input logic [3:0] nib);
      return (nib > BCD_MAX) ? BCD_MAX : nib;
   endfunction

endpackage

// File: rtl/stopwatch_lap_if.sv
// Display bus from the stopwatch to the seven-segment multiplexer.
interface stopwatch_lap_if #(
   parameter int NDIG = 4
);
   import stopwatch_lap_pkg::*;

   // No valid/ready: digits/display are always valid; tick is a one-cycle strobe
   // marking the first cycle a new count is visible, rollover marks a wrapped value.
   logic [4*NDIG-1:0] digits;
   logic [4*NDIG-1:0] display;
   logic              holding;
   logic              tick;
   logic              rollover;
   logic              at_limit;
   lap_state_e        lap_state;

   modport master (output digits, display, holding, tick, rollover, at_limit, lap_state);
   modport slave  (input  digits, display, holding, tick, rollover, at_limit, lap_state);

endinterface

// File: rtl/stopwatch_lap_bcd_digit_updn.sv
// One BCD digit of the ripple counter: up/down step with carry/borrow, or clamped preset.
module bcd_digit_updn
   import stopwatch_lap_pkg::*;
(
   input  logic [3:0] digit_i,
   input  logic       up_i,
   input  logic       cin_i,
   input  logic       load_i,
   input  logic [3:0] load_nib_i,
   output logic [3:0] digit_o,
   output logic       cout_o
);

   always_comb begin
      digit_o = digit_i;
      cout_o  = 1'b0;
      if (load_i) begin
         digit_o = clamp_bcd(load_nib_i);
      end else if (cin_i) begin
         if (up_i) begin
            if (digit_i >= BCD_MAX) begin
               digit_o = BCD_MIN;
               cout_o  = 1'b1;
            end else begin
               digit_o = digit_i + 4'd1;
            end
         end else begin
            if (digit_i == BCD_MIN) begin
               digit_o = BCD_MAX;
               cout_o  = 1'b1;
            end else begin
               digit_o = digit_i - 4'd1;
            end
         end
      end
   end

endmodule

// File: rtl/stopwatch_lap.sv
// Prescaled NDIG-digit BCD up/down stopwatch with wrap/saturate limits,
// clear/preset and a lap-hold display register.
module stopwatch_lap
   import stopwatch_lap_pkg::*;
#(
   parameter int DVSR = 5000000,
   parameter int N    = 23,
   parameter int NDIG = 4,
   parameter int WRAP = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic              up,
   input  logic              clear,
   input  logic              load,
   input  logic [4*NDIG-1:0] load_value,
   input  logic              lap,
   stopwatch_lap_if.master   bus
);

   logic [N-1:0]      cnt_q, cnt_d;
   logic              tick_en;
   logic [4*NDIG-1:0] digits_q, digits_d;
   logic [4*NDIG-1:0] step_val;
   logic [NDIG:0]     carry;
   logic              tick_q, tick_d;
   logic              rollover_q, rollover_d;
   lap_state_e        state_q, state_d;
   logic [4*NDIG-1:0] hold_q, hold_d;

   assign tick_en = enable && (cnt_q == N'(DVSR - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (clear || load || tick_en) begin
         cnt_d = '0;
      end else if (enable) begin
         cnt_d = cnt_q + N'(1);
      end
   end

   // Carry out of the top digit means the step crossed the count limit.
   assign carry[0] = tick_en;
   for (genvar g = 0; g < NDIG; g++) begin : g_digit
      bcd_digit_updn u_digit (
         .digit_i    (digits_q[4*g +: 4]),
         .up_i       (up),
         .cin_i      (carry[g]),
         .load_i     (load),
         .load_nib_i (load_value[4*g +: 4]),
         .digit_o    (step_val[4*g +: 4]),
         .cout_o     (carry[g+1])
      );
   end

   always_comb begin
      digits_d   = digits_q;
      tick_d     = 1'b0;
      rollover_d = 1'b0;
      if (clear) begin
         digits_d = '0;
      end else if (load) begin
         digits_d = step_val;
      end else if (tick_en) begin
         tick_d = 1'b1;
         if (carry[NDIG] && (WRAP == 0)) begin
            digits_d = digits_q;
         end else begin
            digits_d   = step_val;
            rollover_d = carry[NDIG];
         end
      end
   end

   // Capture uses digits_q, so a lap coinciding with a tick holds the pre-tick value.
   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      if (clear) begin
         state_d = LAP_LIVE;
      end else if (lap) begin
         case (state_q)
            LAP_LIVE: begin
               state_d = LAP_HOLD;
               hold_d  = digits_q;
            end
            LAP_HOLD: state_d = LAP_LIVE;
            default:  state_d = LAP_LIVE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q      <= '0;
         digits_q   <= '0;
         tick_q     <= 1'b0;
         rollover_q <= 1'b0;
         state_q    <= LAP_LIVE;
         hold_q     <= '0;
      end else begin
         cnt_q      <= cnt_d;
         digits_q   <= digits_d;
         tick_q     <= tick_d;
         rollover_q <= rollover_d;
         state_q    <= state_d;
         hold_q     <= hold_d;
      end
   end

   assign bus.digits    = digits_q;
   assign bus.display   = (state_q == LAP_HOLD) ? hold_q : digits_q;
   assign bus.holding   = (state_q == LAP_HOLD);
   assign bus.tick      = tick_q;
   assign bus.rollover  = rollover_q;
   assign bus.lap_state = state_q;
   assign bus.at_limit  = (up && (digits_q == {NDIG{BCD_MAX}})) || (!up && (digits_q == '0));

endmodule

// File: tb/tb_stopwatch_lap.sv
// Directed bench for stopwatch_lap: a wrapping and a saturating instance share stimulus;
// a tick monitor pops {rollover, digits} expectations from a queue.
module tb_stopwatch_lap;
   import stopwatch_lap_pkg::*;

   localparam int NDIG = 4;
   localparam int W    = 4 * NDIG;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst_n, enable, up, clear, load, lap;
   logic [W-1:0] load_value;

   stopwatch_lap_if #(.NDIG(NDIG)) bus_w ();
   stopwatch_lap_if #(.NDIG(NDIG)) bus_s ();

   stopwatch_lap #(.DVSR(10), .N(4), .NDIG(NDIG), .WRAP(1)) u_wrap (
      .clk(clk), .reset(rst_n), .enable(enable), .up(up), .clear(clear),
      .load(load), .load_value(load_value), .lap(lap), .bus(bus_w));

   stopwatch_lap #(.DVSR(10), .N(4), .NDIG(NDIG), .WRAP(0)) u_sat (
      .clk(clk), .reset(rst_n), .enable(enable), .up(up), .clear(clear),
      .load(load), .load_value(load_value), .lap(lap), .bus(bus_s));

   int         n_checks = 0;
   int         n_pass   = 0;
   logic [W:0] exp_q[$];
   bit         mon_on   = 1'b0;
   bit         sel_sat  = 1'b0;
   int         tick_cnt = 0;
   int         roll_cnt = 0;

   logic         tick_s, roll_s;
   logic [W-1:0] digits_s;
   assign tick_s   = sel_sat ? bus_s.tick     : bus_w.tick;
   assign roll_s   = sel_sat ? bus_s.rollover : bus_w.rollover;
   assign digits_s = sel_sat ? bus_s.digits   : bus_w.digits;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   // Scoreboard: every tick of the selected instance consumes one expectation.
   always @(negedge clk) begin
      if (mon_on && rst_n) begin
         if (tick_s) begin
            tick_cnt++;
            chk("tick_pending", (exp_q.size() > 0), 1'b1);
            if (exp_q.size() > 0) chk("tick_value", {roll_s, digits_s}, exp_q.pop_front());
         end
         if (roll_s) begin
            roll_cnt++;
            chk("roll_with_tick", tick_s, 1'b1);
         end
      end
   end

   initial begin
      #100000;
      $error("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int first;
      int t0;
      int r0;
      rst_n = 1'b1; enable = 1'b0; up = 1'b1; clear = 1'b0; load = 1'b0; lap = 1'b0;
      load_value = '0;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_digits",   bus_w.digits,   16'h0000);
      chk("rst_display",  bus_w.display,  16'h0000);
      chk("rst_holding",  bus_w.holding,  1'b0);
      chk("rst_tick",     bus_w.tick,     1'b0);
      chk("rst_rollover", bus_w.rollover, 1'b0);

      // 1: count up from reset release
      @(negedge clk); @(negedge clk); #1;
      rst_n = 1'b1; enable = 1'b1; up = 1'b1; mon_on = 1'b1;
      for (int i = 1; i <= 9; i++) exp_q.push_back({1'b0, W'(i)});
      exp_q.push_back({1'b0, 16'h0010});
      first = -1;
      for (int c = 1; c <= 100; c++) begin
         cyc(1);
         if (bus_w.tick && first < 0) first = c;
      end
      chk("s1_first_tick_edge", first, 10);
      chk("s1_digits", bus_w.digits, 16'h0010);
      chk("s1_tick_count", tick_cnt, 10);
      chk("s1_queue", exp_q.size(), 0);

      // 2: wrap past 9999
      load_value = 16'h9998; load = 1'b1;
      cyc(1);
      load = 1'b0;
      chk("s2_load", bus_w.digits, 16'h9998);
      chk("s2_load_no_tick", bus_w.tick, 1'b0);
      chk("s2_at_limit_lo", bus_w.at_limit, 1'b0);
      exp_q.push_back({1'b0, 16'h9999});
      exp_q.push_back({1'b1, 16'h0000});
      r0 = roll_cnt;
      cyc(20);
      chk("s2_digits", bus_w.digits, 16'h0000);
      chk("s2_roll_count", roll_cnt - r0, 1);
      chk("s2_queue", exp_q.size(), 0);

      // 3: saturate at 0000 counting down
      sel_sat = 1'b1;
      load_value = 16'h0001; load = 1'b1; up = 1'b0;
      cyc(1);
      load = 1'b0;
      chk("s3_load", bus_s.digits, 16'h0001);
      repeat (3) exp_q.push_back({1'b0, 16'h0000});
      r0 = roll_cnt; t0 = tick_cnt;
      cyc(30);
      chk("s3_digits", bus_s.digits, 16'h0000);
      chk("s3_at_limit", bus_s.at_limit, 1'b1);
      chk("s3_tick_count", tick_cnt - t0, 3);
      chk("s3_roll_count", roll_cnt - r0, 0);
      chk("s3_queue", exp_q.size(), 0);

      // 4: lap hold while counting
      sel_sat = 1'b0; up = 1'b1; clear = 1'b1;
      cyc(1);
      clear = 1'b0;
      chk("s4_clear", bus_w.digits, 16'h0000);
      for (int i = 1; i <= 3; i++) exp_q.push_back({1'b0, W'(i)});
      cyc(30);
      chk("s4_digits3", bus_w.digits, 16'h0003);
      lap = 1'b1;
      cyc(1);
      lap = 1'b0;
      chk("s4_hold_enter", bus_w.holding, 1'b1);
      chk("s4_hold_display", bus_w.display, 16'h0003);
      for (int i = 4; i <= 8; i++) exp_q.push_back({1'b0, W'(i)});
      cyc(49);
      chk("s4_digits8", bus_w.digits, 16'h0008);
      chk("s4_display_frozen", bus_w.display, 16'h0003);
      chk("s4_holding", bus_w.holding, 1'b1);
      lap = 1'b1;
      cyc(1);
      lap = 1'b0;
      chk("s4_live_display", bus_w.display, 16'h0008);
      chk("s4_live_holding", bus_w.holding, 1'b0);

      // 5: freeze with enable low at prescaler phase 4
      cyc(3);
      enable = 1'b0; t0 = tick_cnt;
      cyc(25);
      chk("s5_frozen_digits", bus_w.digits, 16'h0008);
      chk("s5_frozen_ticks", tick_cnt - t0, 0);
      enable = 1'b1;
      exp_q.push_back({1'b0, 16'h0009});
      cyc(5);
      chk("s5_no_early_tick", tick_cnt - t0, 0);
      cyc(1);
      chk("s5_resume_tick", bus_w.tick, 1'b1);
      chk("s5_resume_digits", bus_w.digits, 16'h0009);

      // 6a: clear wins over a coincident tick and drops the hold
      lap = 1'b1;
      cyc(1);
      lap = 1'b0;
      cyc(8);
      chk("s6_pre_clear_hold", bus_w.holding, 1'b1);
      t0 = tick_cnt; clear = 1'b1;
      cyc(1);
      clear = 1'b0;
      chk("s6_clear_digits", bus_w.digits, 16'h0000);
      chk("s6_clear_no_tick", bus_w.tick, 1'b0);
      chk("s6_clear_holding", bus_w.holding, 1'b0);
      chk("s6_clear_display", bus_w.display, 16'h0000);
      chk("s6_clear_ticks", tick_cnt - t0, 0);

      // 6b: preset with illegal nibbles clamped
      load_value = 16'hA9F3; load = 1'b1;
      cyc(1);
      load = 1'b0;
      chk("s6_load_clamp_w", bus_w.digits, 16'h9993);
      chk("s6_load_clamp_s", bus_s.digits, 16'h9993);

      // 6c: lap on the tick edge captures the pre-tick value
      cyc(9);
      lap = 1'b1;
      exp_q.push_back({1'b0, 16'h9994});
      cyc(1);
      lap = 1'b0;
      chk("s6_lap_tick_digits", bus_w.digits, 16'h9994);
      chk("s6_lap_tick_display", bus_w.display, 16'h9993);
      chk("s6_lap_tick_holding", bus_w.holding, 1'b1);

      // 6d: asynchronous reset mid-count
      cyc(4);
      rst_n = 1'b0;
      #1;
      chk("s6_arst_digits", bus_w.digits, 16'h0000);
      chk("s6_arst_display", bus_w.display, 16'h0000);
      chk("s6_arst_holding", bus_w.holding, 1'b0);
      chk("s6_arst_tick", bus_w.tick, 1'b0);
      chk("s6_arst_rollover", bus_w.rollover, 1'b0);
      chk("s6_arst_sat_digits", bus_s.digits, 16'h0000);
      #14 rst_n = 1'b1;
      cyc(2);
      chk("s6_post_rst_digits", bus_w.digits, 16'h0000);
      mon_on = 1'b0;
      chk("final_queue", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
